multiplier_controller_tainttrack: RTL and testbench

Sequencing FSM for the taint-tracked shift-add multiplier datapath. It drives the datapath load/clear/shift strobes and their taint bits, and walks a bit counter over multiplierReg. It mirrors every control decision into a sticky control-taint bit, so a secret-dependent schedule shows up as tainted control.

---
 rtl/multiplier_controller_tainttrack_pkg.sv | 59 +++++
 rtl/multiplier_controller_tainttrack_bit_select.sv | 21 ++
 rtl/multiplier_controller_tainttrack.sv | 115 +++++++++++
 tb/tb_multiplier_controller_tainttrack.sv | 237 +++++++++++++++++++++++
 4 files changed

// File: rtl/multiplier_controller_tainttrack_pkg.sv
// Shared definitions for the taint-tracked shift-add multiplier: state
// encoding, strobe bundle, default operand width and counter sizing.
package multiplier_pkg;

  localparam int unsigned DEFAULT_WIDTH = 1024;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    INIT  = 3'd1,
    TEST  = 3'd2,
    ADD   = 3'd3,
    SHIFT = 3'd4,
    DONE  = 3'd5
  } mul_state_e;

  typedef struct packed {
    logic mrld;
    logic mdld;
    logic rsclear;
    logic rsload;
    logic rsshr;
    logic busy;
    logic done;
  } mul_ctrl_t;

  // A one-bit operand still needs a one-bit counter.
  function automatic int unsigned cnt_width(input int unsigned width);
    return (width > 1) ? $clog2(width) : 1;
  endfunction

  function automatic mul_ctrl_t decode_state(input mul_state_e s);
    mul_ctrl_t c;
    c = '0;
    case (s)
      INIT: begin
        c.mrld    = 1'b1;
        c.mdld    = 1'b1;
        c.rsclear = 1'b1;
        c.busy    = 1'b1;
      end
      TEST: c.busy = 1'b1;
      ADD: begin
        c.rsload = 1'b1;
        c.busy   = 1'b1;
      end
      SHIFT: begin
        c.rsshr = 1'b1;
        c.busy  = 1'b1;
      end
      DONE: begin
        c.done = 1'b1;
        c.busy = 1'b1;
      end
      default: c = '0;
    endcase
    return c;
  endfunction

endpackage

// File: rtl/multiplier_controller_tainttrack_bit_select.sv
// WIDTH:1 mux picking one multiplier bit and its taint with a single index,
// so the value and its taint can never come from different positions.
module mul_bit_select_tainttrack
  import multiplier_pkg::*;
#(
  parameter int unsigned WIDTH = DEFAULT_WIDTH,
  parameter int unsigned CNT_W = cnt_width(WIDTH)
) (
  input  logic [WIDTH-1:0] multiplierReg,
  input  logic [WIDTH-1:0] multiplierReg_t,
  input  logic [CNT_W-1:0] cnt,
  output logic             bit_o,
  output logic             bit_t
);

  always_comb begin
    bit_o = multiplierReg[cnt];
    bit_t = multiplierReg_t[cnt];
  end

endmodule

// File: rtl/multiplier_controller_tainttrack.sv
// Sequencing FSM for the shift-add multiplier datapath; every control
// decision is folded into a sticky control-taint bit driving all *_t outputs.
module multiplier_controller_tainttrack
  import multiplier_pkg::*;
#(
  parameter int unsigned WIDTH = DEFAULT_WIDTH,
  parameter int unsigned CNT_W = cnt_width(WIDTH)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             start_t,
  input  logic [WIDTH-1:0] multiplierReg,
  input  logic [WIDTH-1:0] multiplierReg_t,
  output logic             mrld,
  output logic             mrld_t,
  output logic             mdld,
  output logic             mdld_t,
  output logic             rsclear,
  output logic             rsclear_t,
  output logic             rsload,
  output logic             rsload_t,
  output logic             rsshr,
  output logic             rsshr_t,
  output logic             busy,
  output logic             busy_t,
  output logic             done,
  output logic             done_t
);

  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WIDTH - 1);

  mul_state_e       state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             ctrl_t_q, ctrl_t_d;
  mul_ctrl_t        ctrl_q, ctrl_d;
  logic             sel_bit;
  logic             sel_bit_t;

  mul_bit_select_tainttrack #(
    .WIDTH (WIDTH),
    .CNT_W (CNT_W)
  ) u_bit_select (
    .multiplierReg   (multiplierReg),
    .multiplierReg_t (multiplierReg_t),
    .cnt             (cnt_q),
    .bit_o           (sel_bit),
    .bit_t           (sel_bit_t)
  );

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    ctrl_t_d = ctrl_t_q;
    case (state_q)
      IDLE: begin
        if (start) begin
          state_d  = INIT;
          cnt_d    = '0;
          ctrl_t_d = start_t;
        end
      end
      INIT: state_d = TEST;
      TEST: begin
        state_d  = sel_bit ? ADD : SHIFT;
        ctrl_t_d = ctrl_t_q | sel_bit_t;
      end
      ADD: state_d = SHIFT;
      SHIFT: begin
        if (cnt_q == CNT_LAST) begin
          state_d = DONE;
        end else begin
          cnt_d   = cnt_q + CNT_W'(1);
          state_d = TEST;
        end
      end
      DONE: state_d = IDLE;
      default: state_d = IDLE;
    endcase
    // Outputs are decoded from the next state so they register alongside it.
    ctrl_d = decode_state(state_d);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= IDLE;
      cnt_q    <= '0;
      ctrl_t_q <= 1'b0;
      ctrl_q   <= '0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      ctrl_t_q <= ctrl_t_d;
      ctrl_q   <= ctrl_d;
    end
  end

  always_comb begin
    mrld      = ctrl_q.mrld;
    mdld      = ctrl_q.mdld;
    rsclear   = ctrl_q.rsclear;
    rsload    = ctrl_q.rsload;
    rsshr     = ctrl_q.rsshr;
    busy      = ctrl_q.busy;
    done      = ctrl_q.done;
    mrld_t    = ctrl_t_q;
    mdld_t    = ctrl_t_q;
    rsclear_t = ctrl_t_q;
    rsload_t  = ctrl_t_q;
    rsshr_t   = ctrl_t_q;
    busy_t    = ctrl_t_q;
    done_t    = ctrl_t_q;
  end

endmodule

// File: tb/tb_multiplier_controller_tainttrack.sv
// Directed bench: two controllers (WIDTH=4 and WIDTH=8) each driving a small
// behavioural shift-add datapath.
module tb_multiplier_controller_tainttrack;

  logic clk;
  logic rst;
  int   total;
  int   bad;

  // WIDTH=4 instance
  logic       start4, start_t4;
  logic [3:0] mr_in4, mrt_in4, md_in4;
  logic [3:0] mr4, mr4_t, md4;
  logic [8:0] acc4;
  logic mrld4, mrld4_t, mdld4, mdld4_t, rsclear4, rsclear4_t;
  logic rsload4, rsload4_t, rsshr4, rsshr4_t, busy4, busy4_t, done4, done4_t;

  // WIDTH=8 instance
  logic        start8, start_t8;
  logic [7:0]  mr_in8, mrt_in8, md_in8;
  logic [7:0]  mr8, mr8_t, md8;
  logic [16:0] acc8;
  logic mrld8, mrld8_t, mdld8, mdld8_t, rsclear8, rsclear8_t;
  logic rsload8, rsload8_t, rsshr8, rsshr8_t, busy8, busy8_t, done8, done8_t;

  logic [6:0] s4, t4, s8, t8;
  assign s4 = {mrld4, mdld4, rsclear4, rsload4, rsshr4, busy4, done4};
  assign t4 = {mrld4_t, mdld4_t, rsclear4_t, rsload4_t, rsshr4_t, busy4_t, done4_t};
  assign s8 = {mrld8, mdld8, rsclear8, rsload8, rsshr8, busy8, done8};
  assign t8 = {mrld8_t, mdld8_t, rsclear8_t, rsload8_t, rsshr8_t, busy8_t, done8_t};

  multiplier_controller_tainttrack #(.WIDTH(4)) dut4 (
    .clk(clk), .rst(rst), .start(start4), .start_t(start_t4),
    .multiplierReg(mr4), .multiplierReg_t(mr4_t),
    .mrld(mrld4), .mrld_t(mrld4_t), .mdld(mdld4), .mdld_t(mdld4_t),
    .rsclear(rsclear4), .rsclear_t(rsclear4_t), .rsload(rsload4), .rsload_t(rsload4_t),
    .rsshr(rsshr4), .rsshr_t(rsshr4_t), .busy(busy4), .busy_t(busy4_t),
    .done(done4), .done_t(done4_t)
  );

  multiplier_controller_tainttrack #(.WIDTH(8)) dut8 (
    .clk(clk), .rst(rst), .start(start8), .start_t(start_t8),
    .multiplierReg(mr8), .multiplierReg_t(mr8_t),
    .mrld(mrld8), .mrld_t(mrld8_t), .mdld(mdld8), .mdld_t(mdld8_t),
    .rsclear(rsclear8), .rsclear_t(rsclear8_t), .rsload(rsload8), .rsload_t(rsload8_t),
    .rsshr(rsshr8), .rsshr_t(rsshr8_t), .busy(busy8), .busy_t(busy8_t),
    .done(done8), .done_t(done8_t)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always_ff @(posedge clk) begin
    if (mrld4) begin
      mr4   <= mr_in4;
      mr4_t <= mrt_in4;
    end
    if (mdld4) md4 <= md_in4;
    if (rsclear4)    acc4 <= '0;
    else if (rsload4) acc4 <= acc4 + {1'b0, md4, 4'b0};
    else if (rsshr4)  acc4 <= acc4 >> 1;
  end

  always_ff @(posedge clk) begin
    if (mrld8) begin
      mr8   <= mr_in8;
      mr8_t <= mrt_in8;
    end
    if (mdld8) md8 <= md_in8;
    if (rsclear8)    acc8 <= '0;
    else if (rsload8) acc8 <= acc8 + {1'b0, md8, 8'b0};
    else if (rsshr8)  acc8 <= acc8 >> 1;
  end

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    assert (got === exp) else begin
      bad++;
      $error("FAIL %s: observed=%0d expected=%0d", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic go4(input logic [3:0] mr, input logic [3:0] mrt, input logic [3:0] md, input logic st);
    mr_in4 = mr; mrt_in4 = mrt; md_in4 = md; start_t4 = st;
    start4 = 1'b1;
    tick();
    start4 = 1'b0;
  endtask

  // Called in the INIT cycle (k=0); returns at the DONE cycle or after the bound.
  task automatic wait_done(input bit w8, output int k, output int busy_cnt, output bit saw_load,
                           output int first_t, output logic [6:0] first_s,
                           output int all_t_cnt, output bit bad_shape);
    logic [6:0] s, t;
    k = 0; busy_cnt = 0; saw_load = 1'b0; first_t = -1; first_s = '0;
    all_t_cnt = 0; bad_shape = 1'b0;
    while (1) begin
      s = w8 ? s8 : s4;
      t = w8 ? t8 : t4;
      if (s[1]) busy_cnt++;
      if (s[3]) saw_load = 1'b1;
      if (first_t < 0 && t != 7'd0) begin
        first_t = k;
        first_s = s;
      end
      if (t == 7'h7f) all_t_cnt++;
      if (t != 7'd0 && t != 7'h7f) bad_shape = 1'b1;
      if ((s[3] && s[2]) || ((s[6] | s[5] | s[4]) && (s[3] | s[2]))) bad_shape = 1'b1;
      if (s[0] || k >= 200) break;
      tick();
      k++;
    end
  endtask

  int k, busy_cnt, first_t, all_t_cnt;
  bit saw_load, bad_shape;
  logic [6:0] first_s;

  initial begin
    total = 0; bad = 0;
    rst = 1'b1;
    start4 = 1'b0; start_t4 = 1'b0; mr_in4 = '0; mrt_in4 = '0; md_in4 = '0;
    start8 = 1'b0; start_t8 = 1'b0; mr_in8 = '0; mrt_in8 = '0; md_in8 = '0;
    tick();
    tick();
    check("rst_out4", {57'd0, s4}, 64'd0);
    check("rst_taint4", {57'd0, t4}, 64'd0);
    check("rst_out8", {57'd0, s8}, 64'd0);
    rst = 1'b0;
    tick();
    check("idle_out4", {57'd0, s4}, 64'd0);

    // 1: 13*11, multiplier 1011 -> DONE after edge 12
    go4(4'd11, 4'd0, 4'd13, 1'b0);
    check("t1_init", {57'd0, s4}, 64'b1110010);
    wait_done(1'b0, k, busy_cnt, saw_load, first_t, first_s, all_t_cnt, bad_shape);
    check("t1_edges", k, 12);
    check("t1_busy_cycles", busy_cnt, 13);
    check("t1_product", {56'd0, acc4[7:0]}, 143);
    check("t1_taint", first_t, -1);
    check("t1_shape", bad_shape, 0);
    tick();
    check("t1_idle", {57'd0, s4}, 64'd0);

    // 2: multiplier 0 -> no rsload, DONE after edge 9
    go4(4'd0, 4'd0, 4'd15, 1'b0);
    wait_done(1'b0, k, busy_cnt, saw_load, first_t, first_s, all_t_cnt, bad_shape);
    check("t2_edges", k, 9);
    check("t2_no_rsload", saw_load, 0);
    check("t2_product", {56'd0, acc4[7:0]}, 0);
    tick();

    // 3: multiplier 0101, only bit 2 tainted -> first tainted cycle is ADD for bit 2
    go4(4'b0101, 4'b0100, 4'd3, 1'b0);
    wait_done(1'b0, k, busy_cnt, saw_load, first_t, first_s, all_t_cnt, bad_shape);
    check("t3_edges", k, 11);
    check("t3_first_taint_k", first_t, 7);
    check("t3_first_taint_strobe", {57'd0, first_s}, 64'b0001010);
    check("t3_done_t", done4_t, 1);
    check("t3_product", {56'd0, acc4[7:0]}, 15);
    check("t3_shape", bad_shape, 0);
    tick();
    check("t3_sticky_idle", {57'd0, t4}, 64'h7f);
    go4(4'd2, 4'd0, 4'd7, 1'b0);
    check("t3_reload_clear", {57'd0, t4}, 64'd0);
    wait_done(1'b0, k, busy_cnt, saw_load, first_t, first_s, all_t_cnt, bad_shape);
    check("t3b_edges", k, 10);
    check("t3b_product", {56'd0, acc4[7:0]}, 14);
    check("t3b_taint", first_t, -1);
    tick();

    // 4: tainted start -> all taints high from INIT through DONE and after
    go4(4'd11, 4'd0, 4'd5, 1'b1);
    check("t4_init_taint", {61'd0, mrld4_t, mdld4_t, rsclear4_t}, 64'b111);
    wait_done(1'b0, k, busy_cnt, saw_load, first_t, first_s, all_t_cnt, bad_shape);
    check("t4_edges", k, 12);
    check("t4_all_tainted", all_t_cnt, 13);
    check("t4_product", {56'd0, acc4[7:0]}, 55);
    tick();
    check("t4_idle_taint", {57'd0, t4}, 64'h7f);
    check("t4_idle_busy", busy4, 0);

    // 5: start during SHIFT at cnt=2 ignored; reset during ADD
    go4(4'd15, 4'd0, 4'd15, 1'b1);
    for (int i = 0; i < 9; i++) tick();
    check("t5_shift_c2", {57'd0, s4}, 64'b0000110);
    start4 = 1'b1;
    tick();
    start4 = 1'b0;
    check("t5_start_ignored", {57'd0, s4}, 64'b0000010);
    tick();
    check("t5_add", {57'd0, s4}, 64'b0001010);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check("t5_rst_out", {57'd0, s4}, 64'd0);
    check("t5_rst_taint", {57'd0, t4}, 64'd0);
    tick();
    check("t5_stay_idle", {57'd0, s4}, 64'd0);
    go4(4'd15, 4'd0, 4'd15, 1'b0);
    wait_done(1'b0, k, busy_cnt, saw_load, first_t, first_s, all_t_cnt, bad_shape);
    check("t5_edges", k, 13);
    check("t5_product", {56'd0, acc4[7:0]}, 225);
    check("t5_taint", first_t, -1);
    tick();

    // 6: WIDTH=8, start held high -> back-to-back with one IDLE cycle
    mr_in8 = 8'd255; mrt_in8 = '0; md_in8 = 8'd255; start_t8 = 1'b0;
    start8 = 1'b1;
    tick();
    check("t6_init1", {57'd0, s8}, 64'b1110010);
    wait_done(1'b1, k, busy_cnt, saw_load, first_t, first_s, all_t_cnt, bad_shape);
    check("t6_edges1", k, 25);
    check("t6_product1", {47'd0, acc8[15:0]}, 65025);
    tick();
    check("t6_gap_idle", {57'd0, s8}, 64'd0);
    tick();
    check("t6_init2", {57'd0, s8}, 64'b1110010);
    start8 = 1'b0;
    wait_done(1'b1, k, busy_cnt, saw_load, first_t, first_s, all_t_cnt, bad_shape);
    check("t6_edges2", k, 25);
    check("t6_product2", {47'd0, acc8[15:0]}, 65025);
    check("t6_shape", bad_shape, 0);
    tick();
    tick();
    check("t6_final_idle", {57'd0, s8}, 64'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
